tdm_rx_framer: RTL and testbench

Front-end feeding the DSP core. Deserializes an 8-slot TDM serial audio stream (bit clock, frame sync, data) into eight 36-bit parallel sample words. Presents each completed frame on `samples` together with a one-cycle `start` pulse: exactly the `inputs`/`start` contract that `DSPCore` consumes once per audio sample.

---
 rtl/audio_pkg.sv | 19 +
 rtl/tdm_rx_framer_if.sv | 29 ++
 rtl/sync_edge_detect.sv | 42 ++++
 rtl/tdm_rx_framer.sv | 148 ++++++++++++++
 tb/tb_tdm_rx_framer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// Shared audio front-end definitions.
// Holds the TDM frame geometry, the DSP word type and the receive-state
// encoding used by the framer and its interface.
package audio_pkg;

    localparam int N_CHANNELS  = 8;   // TDM slots per frame
    localparam int SLOT_BITS   = 32;  // sclk periods per slot
    localparam int SAMPLE_BITS = 24;  // valid MSB-first bits at the start of a slot
    localparam int WORD_BITS   = 36;  // DSP word width
    localparam int FRAC_SHIFT  = 10;  // zero LSBs appended below the sample

    typedef logic [WORD_BITS-1:0] sample_t;

    typedef enum logic {
        HUNT,
        RECEIVE
    } rx_state_t;

endpackage

// File: rtl/tdm_rx_framer_if.sv
// TDM receive bus: serial pins in, parallel frame out.
//   sclk_in, fsync_in, sdata_in : TDM bit clock, frame sync, serial data
//   samples                     : last complete frame, one word per slot
//   start                       : one-cycle pulse when samples updates
//   locked                      : high while frame alignment is held
//   frame_err                   : one-cycle pulse on an alignment violation
// master drives the serial pins (TDM source side), slave is the framer.
interface tdm_rx_framer_if;
    import audio_pkg::*;

    logic    sclk_in;
    logic    fsync_in;
    logic    sdata_in;
    sample_t samples [N_CHANNELS];
    logic    start;
    logic    locked;
    logic    frame_err;

    modport master (
        output sclk_in, fsync_in, sdata_in,
        input  samples, start, locked, frame_err
    );

    modport slave (
        input  sclk_in, fsync_in, sdata_in,
        output samples, start, locked, frame_err
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with registered rising-edge detection.
//   clk, reset : system clock, asynchronous active-high reset
//   edge_in    : asynchronous clock-like input whose rising edges are reported
//   data_in    : asynchronous inputs that only need synchronizing
//   data_sync  : data_in after two flops
//   rise       : one-cycle pulse, three clk cycles after an edge_in rise
module sync_edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         edge_in,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_sync,
    output logic         rise
);

    logic         edge_p0, edge_p1, edge_p2;
    logic [W-1:0] data_p0, data_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_p0 <= 1'b0;
            edge_p1 <= 1'b0;
            edge_p2 <= 1'b0;
            data_p0 <= '0;
            data_p1 <= '0;
            rise    <= 1'b0;
        end else begin
            // p0/p1: metastability filter; p2: previous synchronized level
            edge_p0 <= edge_in;
            edge_p1 <= edge_p0;
            edge_p2 <= edge_p1;
            data_p0 <= data_in;
            data_p1 <= data_p0;
            rise    <= edge_p1 & ~edge_p2;
        end
    end

    assign data_sync = data_p1;

endmodule

// File: rtl/tdm_rx_framer.sv
// TDM receive framer: deserializes an N_CHANNELS-slot serial audio stream
// into parallel DSP words and presents each complete frame with a start pulse.
//   clk, reset : system clock (>= 8x sclk), asynchronous active-high reset
//   bus        : tdm_rx_framer_if.slave (serial pins in, samples/start/
//                locked/frame_err out)
module tdm_rx_framer
    import audio_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    tdm_rx_framer_if.slave bus
);

    localparam int CNT_W  = $clog2(SLOT_BITS);
    localparam int SLOT_W = $clog2(N_CHANNELS);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_CHANNELS - 1);

    // Sign-extend to the integer part and append the zero fraction bits.
    function automatic sample_t to_word(input logic [SAMPLE_BITS-1:0] s);
        return {{(WORD_BITS-FRAC_SHIFT-SAMPLE_BITS){s[SAMPLE_BITS-1]}}, s, {FRAC_SHIFT{1'b0}}};
    endfunction

    logic       fsync_s, sdata_s, bit_vld;
    logic [1:0] sync_bus;

    sync_edge_detect #(.W(2)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .edge_in   (bus.sclk_in),
        .data_in   ({bus.fsync_in, bus.sdata_in}),
        .data_sync (sync_bus),
        .rise      (bit_vld)
    );

    assign {fsync_s, sdata_s} = sync_bus;

    rx_state_t              state, state_nxt;
    logic [CNT_W-1:0]       bit_cnt, cnt_nxt;
    logic [SLOT_W-1:0]      slot, slot_nxt;
    logic [SLOT_BITS-2:0]   shift_q, shift_nxt;
    logic                   expect_sync, expect_nxt;
    logic                   latch, complete, err;
    logic [SLOT_BITS-1:0]   word_now;
    logic [SAMPLE_BITS-1:0] slot_sample;
    logic [SAMPLE_BITS-1:0] staging_q [N_CHANNELS];
    sample_t                samples_q [N_CHANNELS];
    logic                   start_q, frame_err_q;

    // The shift register holds the bits received so far; the current bit
    // completes the slot word without an extra register stage.
    assign word_now    = {shift_q, sdata_s};
    assign slot_sample = word_now[SLOT_BITS-1 -: SAMPLE_BITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = bit_cnt;
        slot_nxt   = slot;
        shift_nxt  = shift_q;
        expect_nxt = expect_sync;
        latch      = 1'b0;
        complete   = 1'b0;
        err        = 1'b0;
        if (bit_vld) begin
            case (state)
                HUNT: begin
                    if (fsync_s) begin
                        state_nxt  = RECEIVE;
                        shift_nxt  = word_now[SLOT_BITS-2:0];
                        cnt_nxt    = CNT_W'(1);
                        slot_nxt   = '0;
                        expect_nxt = 1'b0;
                    end
                end
                RECEIVE: begin
                    if (fsync_s && !expect_sync) begin
                        // Early frame sync: drop the partial frame and treat
                        // this bit as slot 0 bit 1 of a new frame.
                        err        = 1'b1;
                        shift_nxt  = word_now[SLOT_BITS-2:0];
                        cnt_nxt    = CNT_W'(1);
                        slot_nxt   = '0;
                    end else if (!fsync_s && expect_sync) begin
                        err        = 1'b1;
                        state_nxt  = HUNT;
                        expect_nxt = 1'b0;
                    end else begin
                        shift_nxt  = word_now[SLOT_BITS-2:0];
                        expect_nxt = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            latch    = 1'b1;
                            cnt_nxt  = '0;
                            slot_nxt = slot + 1'b1;
                            if (slot == SLOT_LAST) begin
                                complete   = 1'b1;
                                expect_nxt = 1'b1;
                                slot_nxt   = '0;
                            end
                        end else begin
                            cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            slot        <= '0;
            shift_q     <= '0;
            expect_sync <= 1'b0;
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < N_CHANNELS; k++) begin
                staging_q[k] <= '0;
                samples_q[k] <= '0;
            end
        end else begin
            bit_cnt     <= cnt_nxt;
            slot        <= slot_nxt;
            shift_q     <= shift_nxt;
            expect_sync <= expect_nxt;
            start_q     <= complete;
            frame_err_q <= err;
            if (latch) staging_q[slot] <= slot_sample;
            // The last slot bypasses staging so the whole frame lands together.
            if (complete) begin
                for (int k = 0; k < N_CHANNELS; k++) begin
                    samples_q[k] <= to_word((k == N_CHANNELS - 1) ? slot_sample : staging_q[k]);
                end
            end
        end
    end

    assign bus.samples   = samples_q;
    assign bus.start     = start_q;
    assign bus.locked    = (state == RECEIVE);
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_rx_framer.sv
// Testbench for tdm_rx_framer: frames are generated as slot values, the
// expected start/frame_err events are queued from frame-level rules, and a
// monitor compares every event the framer emits against the queue.
module tb_tdm_rx_framer;
    import audio_pkg::*;

    typedef struct packed {
        logic             is_start;
        logic             lk;
        logic [7:0][35:0] w;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tdm_rx_framer_if bus ();

    tdm_rx_framer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ev_t  q [$];
    int   st [$];
    int   n_start_exp = 0;
    int   cyc = 0;
    bit   m_lk  = 1'b0;   // model: framer holds alignment
    bit   m_exp = 1'b0;   // model: next bit must carry fsync

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Sample value scaled into the DSP word: signed value times 2^FRAC_SHIFT.
    function automatic logic [35:0] fmt(input logic [23:0] s);
        longint v;
        v = longint'(s);
        if (v >= (longint'(1) << 23)) v = v - (longint'(1) << 24);
        return 36'(v * 1024);
    endfunction

    task automatic push_start(input logic [7:0][23:0] s);
        ev_t e;
        e = '0;
        e.is_start = 1'b1;
        e.lk       = 1'b1;
        for (int k = 0; k < 8; k++) e.w[k] = fmt(s[k]);
        q.push_back(e);
        n_start_exp++;
    endtask

    task automatic push_err(input logic lk);
        ev_t e;
        e = '0;
        e.lk = lk;
        q.push_back(e);
    endtask

    task automatic drive_bit(input logic f, input logic d);
        bus.fsync_in = f;
        bus.sdata_in = d;
        #40 bus.sclk_in = 1'b1;
        #40 bus.sclk_in = 1'b0;
    endtask

    // Send one frame; stop_at >= 0 cuts it short before that bit index.
    task automatic run_frame(input logic [7:0][23:0] s, input bit sync,
                             input int stop_at, input bit trail_ones);
        if (sync) begin
            if (m_lk && !m_exp) push_err(1'b1);
            m_lk = 1'b1;
            if (stop_at < 0) push_start(s);
        end else if (m_lk && m_exp) begin
            push_err(1'b0);
            m_lk = 1'b0;
        end
        m_exp = 1'b0;
        for (int idx = 0; idx < 256; idx++) begin
            int   k;
            int   b;
            logic d;
            if (idx == stop_at) return;
            k = idx / 32;
            b = idx % 32;
            if (b < 24) d = s[k][23-b];
            else        d = trail_ones ? 1'b1 : 1'($urandom_range(0, 1));
            drive_bit(sync && (idx == 0), d);
        end
        if (sync) m_exp = 1'b1;
    endtask

    task automatic rand_frame(output logic [7:0][23:0] s);
        for (int k = 0; k < 8; k++) s[k] = 24'($urandom);
    endtask

    // Monitor / scoreboard
    logic [35:0] held [8];
    bit          hold_bad   = 1'b0;
    logic        prev_start = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            for (int k = 0; k < 8; k++) held[k] = '0;
            hold_bad   = 1'b0;
            prev_start = 1'b0;
        end else begin
            cyc++;
            if (bus.start) begin
                chk("start_single_cycle", prev_start, 1'b0);
                chk("start_vs_frame_err", bus.frame_err, 1'b0);
                chk("samples_held_between_starts", hold_bad, 1'b0);
                hold_bad = 1'b0;
                chk("start_expected", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("event_is_start", 1'b1, e.is_start);
                    if (e.is_start) begin
                        for (int k = 0; k < 8; k++)
                            chk($sformatf("samples[%0d]", k), bus.samples[k], e.w[k]);
                        chk("locked_at_start", bus.locked, e.lk);
                    end
                end
                for (int k = 0; k < 8; k++) held[k] = bus.samples[k];
                st.push_back(cyc);
            end else begin
                for (int k = 0; k < 8; k++)
                    if (bus.samples[k] !== held[k]) hold_bad = 1'b1;
                if (bus.frame_err) begin
                    chk("frame_err_expected", q.size() > 0, 1'b1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("event_is_frame_err", 1'b0, e.is_start);
                        chk("locked_at_frame_err", bus.locked, e.lk);
                    end
                end
            end
            prev_start = bus.start;
        end
    end

    initial begin
        logic [7:0][23:0] s;
        bus.sclk_in  = 1'b0;
        bus.fsync_in = 1'b0;
        bus.sdata_in = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_start", bus.start, 1'b0);
        chk("reset_locked", bus.locked, 1'b0);
        chk("reset_frame_err", bus.frame_err, 1'b0);
        for (int k = 0; k < 8; k++) chk($sformatf("reset_samples[%0d]", k), bus.samples[k], 36'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        // Directed clean frame
        for (int k = 0; k < 8; k++) s[k] = 24'(k);
        s[0] = 24'h7FFFFF;
        s[1] = 24'h800000;
        run_frame(s, 1'b1, -1, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        chk("directed_samples[0]", bus.samples[0], 36'h1FFFFFC00);
        chk("directed_samples[1]", bus.samples[1], 36'hE00000000);
        chk("directed_samples[2]", bus.samples[2], 36'h000000800);
        chk("directed_samples[7]", bus.samples[7], 36'h000001C00);
        chk("directed_locked", bus.locked, 1'b1);

        // Three back-to-back frames, the middle one with trailing bits all 1
        for (int i = 0; i < 3; i++) begin
            rand_frame(s);
            run_frame(s, 1'b1, -1, i == 1);
        end
        repeat (8) @(posedge clk);
        #2;
        chk("start_count_after_b2b", st.size(), 4);
        if (st.size() >= 4) begin
            chk("b2b_interval_1", st[2] - st[1], 2048);
            chk("b2b_interval_2", st[3] - st[2], 2048);
        end

        // Early fsync at slot 3 bit 5, then a full frame
        rand_frame(s);
        run_frame(s, 1'b1, 3 * 32 + 4, 1'b0);
        rand_frame(s);
        run_frame(s, 1'b1, -1, 1'b0);
        repeat (8) @(posedge clk);
        #2;
        chk("locked_after_early_fsync", bus.locked, 1'b1);

        // Missing fsync at frame boundary, then a fresh frame
        rand_frame(s);
        run_frame(s, 1'b0, -1, 1'b0);
        chk("locked_after_missing_fsync", bus.locked, 1'b0);
        rand_frame(s);
        run_frame(s, 1'b1, -1, 1'b0);

        // Reset in slot 4
        rand_frame(s);
        run_frame(s, 1'b1, 4 * 32 + 10, 1'b0);
        reset = 1'b1;
        #1;
        chk("midreset_start", bus.start, 1'b0);
        chk("midreset_locked", bus.locked, 1'b0);
        for (int k = 0; k < 8; k++) chk($sformatf("midreset_samples[%0d]", k), bus.samples[k], 36'h0);
        chk("pending_events_at_reset", q.size(), 0);
        q.delete();
        m_lk  = 1'b0;
        m_exp = 1'b0;
        #20 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rand_frame(s);
        run_frame(s, 1'b0, -1, 1'b0);
        rand_frame(s);
        run_frame(s, 1'b1, -1, 1'b0);

        // Randomized mix of clean, aborted and unsynced frames
        for (int i = 0; i < 6; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            rand_frame(s);
            if (r >= 8 && !(m_lk && !m_exp))
                run_frame(s, 1'b0, -1, 1'b0);
            else if (r >= 6)
                run_frame(s, 1'b1, int'($urandom_range(1, 255)), 1'b0);
            else
                run_frame(s, 1'b1, -1, 1'($urandom_range(0, 1)));
        end
        rand_frame(s);
        run_frame(s, 1'b1, -1, 1'b0);

        repeat (20) @(posedge clk);
        #2;
        chk("pending_events_at_end", q.size(), 0);
        chk("start_total", st.size(), n_start_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
